// File: rtl/arbitro_barramento.sv
// rtl/arbitro_barramento.sv - round-robin snooping bus arbiter and memory sequencer
// Grants one L1 per transaction, broadcasts the MESI message, then orders victim/snooper write-backs and the read.
module arbitro_barramento #(
  parameter int N      = 3,
  parameter int ENDR_W = 5,
  parameter int DADO_W = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N-1:0]        req,
  input  logic [2*N-1:0]      msg_req,
  input  logic [ENDR_W*N-1:0] endr_req,
  input  logic [N-1:0]        wb_req,
  input  logic [ENDR_W*N-1:0] endr_wb_req,
  input  logic [DADO_W*N-1:0] dado_wb_req,
  output logic [N-1:0]        gnt,
  output logic [N-1:0]        pronto,
  output logic [DADO_W-1:0]   dado_out,
  output logic                shared_out,
  output logic                bus_valido,
  output logic [1:0]          msg_bus,
  output logic [ENDR_W-1:0]   endr_bus,
  input  logic [N-1:0]        snoop_shared,
  input  logic [N-1:0]        snoop_wb,
  input  logic [DADO_W*N-1:0] snoop_dado,
  output logic                mem_req,
  output logic                mem_w,
  output logic [ENDR_W-1:0]   mem_endr,
  output logic [DADO_W-1:0]   mem_dado_out,
  input  logic [DADO_W-1:0]   mem_dado_in,
  input  logic                mem_pronto
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {OCIOSO, SNOOP, WB_VITIMA, WB_SNOOP, LEITURA, FIM} estado_t;
  estado_t estado, prox;

  logic [IW-1:0]     ultimo, escolha, sel_r;
  logic              tem_escolha;
  logic [N-1:0]      escolha_oh, grant_r, shared_m, wb_m;
  logic [1:0]        msg_sel, msg_r;
  logic [ENDR_W-1:0] endr_sel, endr_r, vit_endr_sel, vit_endr_r;
  logic [DADO_W-1:0] vit_dado_sel, vit_dado_r, dono_dado_sel, dono_dado_r, dado_r;
  logic              wb_sel, wb_r, shared_r, tem_dono_r;

  // Indices above ultimo win over the wrapped ones; within each group the lowest index wins.
  always_comb begin
    escolha      = '0;
    tem_escolha  = 1'b0;
    escolha_oh   = '0;
    msg_sel      = '0;
    endr_sel     = '0;
    wb_sel       = 1'b0;
    vit_endr_sel = '0;
    vit_dado_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && IW'(i) <= ultimo) begin
        escolha     = IW'(i);
        tem_escolha = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && IW'(i) > ultimo) begin
        escolha     = IW'(i);
        tem_escolha = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (escolha == IW'(i)) begin
        escolha_oh[i] = 1'b1;
        msg_sel       = msg_req[2*i +: 2];
        endr_sel      = endr_req[ENDR_W*i +: ENDR_W];
        wb_sel        = wb_req[i];
        vit_endr_sel  = endr_wb_req[ENDR_W*i +: ENDR_W];
        vit_dado_sel  = dado_wb_req[DADO_W*i +: DADO_W];
      end
    end
  end

  // The requester never snoops itself; the lowest-index owner wins on conflicting responses.
  always_comb begin
    shared_m      = snoop_shared & ~grant_r;
    wb_m          = snoop_wb & ~grant_r;
    dono_dado_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (wb_m[i]) dono_dado_sel = snoop_dado[DADO_W*i +: DADO_W];
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      estado      <= OCIOSO;
      ultimo      <= IW'(N - 1);
      sel_r       <= '0;
      grant_r     <= '0;
      msg_r       <= '0;
      endr_r      <= '0;
      wb_r        <= 1'b0;
      vit_endr_r  <= '0;
      vit_dado_r  <= '0;
      shared_r    <= 1'b0;
      tem_dono_r  <= 1'b0;
      dono_dado_r <= '0;
      dado_r      <= '0;
    end else begin
      estado <= prox;
      case (estado)
        OCIOSO: begin
          if (grant_r == '0 && tem_escolha) begin
            sel_r      <= escolha;
            grant_r    <= escolha_oh;
            msg_r      <= (msg_sel == 2'b00) ? 2'b01 : msg_sel;
            endr_r     <= endr_sel;
            wb_r       <= wb_sel;
            vit_endr_r <= vit_endr_sel;
            vit_dado_r <= vit_dado_sel;
          end
        end
        SNOOP: begin
          shared_r    <= |shared_m;
          tem_dono_r  <= |wb_m;
          dono_dado_r <= dono_dado_sel;
        end
        WB_SNOOP: if (mem_pronto) dado_r <= dono_dado_r;
        LEITURA:  if (mem_pronto) dado_r <= mem_dado_in;
        FIM: begin
          grant_r <= '0;
          ultimo  <= sel_r;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prox         = estado;
    pronto       = '0;
    shared_out   = 1'b0;
    bus_valido   = 1'b0;
    msg_bus      = '0;
    endr_bus     = '0;
    mem_req      = 1'b0;
    mem_w        = 1'b0;
    mem_endr     = '0;
    mem_dado_out = '0;
    case (estado)
      OCIOSO: if (grant_r != '0) prox = SNOOP;
      SNOOP: begin
        bus_valido = 1'b1;
        msg_bus    = msg_r;
        endr_bus   = endr_r;
        if (msg_r == 2'b10)  prox = FIM;
        else if (wb_r)       prox = WB_VITIMA;
        else if (|wb_m)      prox = WB_SNOOP;
        else                 prox = LEITURA;
      end
      WB_VITIMA: begin
        mem_req      = 1'b1;
        mem_w        = 1'b1;
        mem_endr     = vit_endr_r;
        mem_dado_out = vit_dado_r;
        if (mem_pronto) prox = tem_dono_r ? WB_SNOOP : LEITURA;
      end
      WB_SNOOP: begin
        mem_req      = 1'b1;
        mem_w        = 1'b1;
        mem_endr     = endr_r;
        mem_dado_out = dono_dado_r;
        if (mem_pronto) prox = FIM;
      end
      LEITURA: begin
        mem_req  = 1'b1;
        mem_endr = endr_r;
        if (mem_pronto) prox = FIM;
      end
      FIM: begin
        pronto     = grant_r;
        shared_out = shared_r;
        prox       = OCIOSO;
      end
      default: prox = OCIOSO;
    endcase
  end

  assign gnt      = grant_r;
  assign dado_out = dado_r;

endmodule

// File: tb/tb_arbitro_barramento.sv
// tb/tb_arbitro_barramento.sv - self-checking bench for arbitro_barramento
// Directed vector table, hand-written corner sequences and a randomized run against a transaction-level model.
module tb_arbitro_barramento;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req = '0;
  logic [5:0]  msg_req = '0;
  logic [14:0] endr_req = '0;
  logic [2:0]  wb_req = '0;
  logic [14:0] endr_wb_req = '0;
  logic [29:0] dado_wb_req = '0;
  logic [2:0]  gnt, pronto;
  logic [9:0]  dado_out;
  logic        shared_out, bus_valido;
  logic [1:0]  msg_bus;
  logic [4:0]  endr_bus;
  logic [2:0]  snoop_shared = '0, snoop_wb = '0;
  logic [29:0] snoop_dado = '0;
  logic        mem_req, mem_w;
  logic [4:0]  mem_endr;
  logic [9:0]  mem_dado_out;
  logic [9:0]  mem_dado_in = '0;
  logic        mem_pronto = 1'b0;

  arbitro_barramento #(.N(3), .ENDR_W(5), .DADO_W(10)) dut (
    .clock(clock), .reset(reset), .req(req), .msg_req(msg_req), .endr_req(endr_req),
    .wb_req(wb_req), .endr_wb_req(endr_wb_req), .dado_wb_req(dado_wb_req),
    .gnt(gnt), .pronto(pronto), .dado_out(dado_out), .shared_out(shared_out),
    .bus_valido(bus_valido), .msg_bus(msg_bus), .endr_bus(endr_bus),
    .snoop_shared(snoop_shared), .snoop_wb(snoop_wb), .snoop_dado(snoop_dado),
    .mem_req(mem_req), .mem_w(mem_w), .mem_endr(mem_endr), .mem_dado_out(mem_dado_out),
    .mem_dado_in(mem_dado_in), .mem_pronto(mem_pronto)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic w, input logic [4:0] a, input logic [9:0] d);
    return {w, a, d};
  endfunction

  // Memory: completes each access after mem_wait idle cycles and logs it.
  int          mem_wait = 0;
  int          wcnt = 0;
  logic [15:0] mem_log[$];
  logic [4:0]  cur_endr;
  logic [9:0]  cur_dado;
  logic        cur_w;

  always @(posedge clock) begin
    if (!mem_req) begin
      mem_pronto = 1'b0;
      wcnt = 0;
    end else begin
      if (mem_pronto) wcnt = 0;
      if (wcnt == 0) begin
        cur_endr = mem_endr;
        cur_dado = mem_dado_out;
        cur_w    = mem_w;
      end else begin
        chk("mem_stable", {mem_w, mem_endr, mem_dado_out}, {cur_w, cur_endr, cur_dado});
      end
      mem_pronto = (wcnt >= mem_wait);
      if (mem_pronto) mem_log.push_back(mk(mem_w, mem_endr, mem_w ? mem_dado_out : 10'h0));
      wcnt++;
    end
  end

  logic [1:0] c_msg[3];
  logic [4:0] c_endr[3], c_vendr[3];
  logic [9:0] c_vdado[3];
  logic       c_wb[3];

  task automatic pack();
    for (int i = 0; i < 3; i++) begin
      msg_req[2*i +: 2]      = c_msg[i];
      endr_req[5*i +: 5]     = c_endr[i];
      wb_req[i]              = c_wb[i];
      endr_wb_req[5*i +: 5]  = c_vendr[i];
      dado_wb_req[10*i +: 10] = c_vdado[i];
    end
  endtask

  typedef struct {
    int         c;
    logic [1:0] msg;
    logic [4:0] endr;
    logic       wb;
    logic [4:0] vendr;
    logic [9:0] vdado;
    logic [2:0] ss;
    logic [2:0] swb;
    logic [29:0] sdado;
    logic [9:0] mdado;
    int         wt;
    logic [2:0] e_gnt;
    logic [1:0] e_msg;
    logic       e_sh;
    logic [9:0] e_dado;
    int         e_n;
    logic [15:0] e_a0;
    logic [15:0] e_a1;
    int         e_lat;
  } vec_t;

  vec_t tab[8];

  task automatic run_vec(input vec_t v);
    int lat, nbv;
    logic gok, mseen, got;
    logic [1:0] bm;
    logic [4:0] be;
    c_msg[v.c] = v.msg; c_endr[v.c] = v.endr; c_wb[v.c] = v.wb;
    c_vendr[v.c] = v.vendr; c_vdado[v.c] = v.vdado;
    pack();
    snoop_shared = v.ss; snoop_wb = v.swb; snoop_dado = v.sdado;
    mem_dado_in = v.mdado; mem_wait = v.wt;
    mem_log.delete();
    req = 3'(1 << v.c);
    got = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(posedge clock);
      if (gnt != 0) begin got = 1'b1; break; end
    end
    chk("vec_gnt", gnt, v.e_gnt);
    if (!got) begin req = '0; return; end
    lat = 0; nbv = 0; gok = 1'b1; mseen = 1'b0; bm = '0; be = '0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clock);
      lat++;
      if (bus_valido) begin nbv++; bm = msg_bus; be = endr_bus; end
      if (mem_req) mseen = 1'b1;
      if (gnt != v.e_gnt) gok = 1'b0;
      if (pronto != 0) break;
    end
    chk("vec_pronto", pronto, v.e_gnt);
    chk("vec_latency", lat, v.e_lat);
    chk("vec_bus_cycles", nbv, 1);
    chk("vec_msg_bus", bm, v.e_msg);
    chk("vec_endr_bus", be, v.endr);
    chk("vec_shared", shared_out, v.e_sh);
    chk("vec_gnt_hold", gok, 1);
    chk("vec_mem_seen", mseen, (v.e_n > 0));
    if (v.e_n > 0) chk("vec_dado", dado_out, v.e_dado);
    chk("vec_log_n", mem_log.size(), v.e_n);
    if (v.e_n >= 1 && mem_log.size() >= 1) chk("vec_acc0", mem_log[0], v.e_a0);
    if (v.e_n >= 2 && mem_log.size() >= 2) chk("vec_acc1", mem_log[1], v.e_a1);
    req = '0;
    @(posedge clock);
    chk("vec_gnt_clr", gnt, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clock); #2 reset = 1'b1;
    @(posedge clock); #2 reset = 1'b0;
  endtask

  function automatic int rr_pick(input logic [2:0] r, input int ult);
    for (int k = 1; k <= 3; k++) if (r[(ult + k) % 3]) return (ult + k) % 3;
    return -1;
  endfunction

  initial begin
    int ord[4];
    int k, np, w, ult_m, t0, own, e_lat, ntx, dropped;
    logic [2:0] prevg, rq_prev, wbm;
    logic [1:0] m;
    logic       e_sh, busy, to, ok;
    logic [9:0] e_dado;
    logic [15:0] exp_q[$];

    for (int i = 0; i < 3; i++) begin
      c_msg[i] = 2'b01; c_endr[i] = '0; c_wb[i] = 1'b0; c_vendr[i] = '0; c_vdado[i] = '0;
    end
    pack();

    tab[0] = '{1, 2'b01, 5'h0A, 1'b0, 5'h00, 10'h000, 3'b000, 3'b000, 30'h0, 10'h155, 0,
               3'b010, 2'b01, 1'b0, 10'h155, 1, mk(0, 5'h0A, 10'h0), 16'h0, 3};
    tab[1] = '{0, 2'b11, 5'h13, 1'b1, 5'h0B, 10'h2AA, 3'b000, 3'b100, {10'h0F0, 10'h0, 10'h0}, 10'h3FF, 0,
               3'b001, 2'b11, 1'b0, 10'h0F0, 2, mk(1, 5'h0B, 10'h2AA), mk(1, 5'h13, 10'h0F0), 4};
    tab[2] = '{0, 2'b10, 5'h07, 1'b0, 5'h00, 10'h000, 3'b110, 3'b000, 30'h0, 10'h000, 0,
               3'b001, 2'b10, 1'b1, 10'h000, 0, 16'h0, 16'h0, 2};
    tab[3] = '{2, 2'b01, 5'h1C, 1'b0, 5'h00, 10'h000, 3'b000, 3'b000, 30'h0, 10'h2B3, 4,
               3'b100, 2'b01, 1'b0, 10'h2B3, 1, mk(0, 5'h1C, 10'h0), 16'h0, 7};
    tab[4] = '{1, 2'b01, 5'h05, 1'b0, 5'h00, 10'h000, 3'b010, 3'b010, {10'h0, 10'h3AA, 10'h0}, 10'h0AB, 0,
               3'b010, 2'b01, 1'b0, 10'h0AB, 1, mk(0, 5'h05, 10'h0), 16'h0, 3};
    tab[5] = '{2, 2'b11, 5'h11, 1'b0, 5'h00, 10'h000, 3'b011, 3'b011, {10'h0, 10'h222, 10'h111}, 10'h000, 0,
               3'b100, 2'b11, 1'b1, 10'h111, 1, mk(1, 5'h11, 10'h111), 16'h0, 3};
    tab[6] = '{0, 2'b00, 5'h02, 1'b0, 5'h00, 10'h000, 3'b000, 3'b000, 30'h0, 10'h3C3, 0,
               3'b001, 2'b01, 1'b0, 10'h3C3, 1, mk(0, 5'h02, 10'h0), 16'h0, 3};
    tab[7] = '{1, 2'b11, 5'h0C, 1'b1, 5'h1F, 10'h155, 3'b000, 3'b000, 30'h0, 10'h0EE, 1,
               3'b010, 2'b11, 1'b0, 10'h0EE, 2, mk(1, 5'h1F, 10'h155), mk(0, 5'h0C, 10'h0), 6};

    #1 reset = 1'b1;
    @(posedge clock); @(posedge clock);
    chk("rst_gnt", gnt, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_dado", dado_out, 0);
    chk("rst_bus", {shared_out, bus_valido, msg_bus, endr_bus}, 0);
    chk("rst_mem", {mem_req, mem_w, mem_endr, mem_dado_out}, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(tab[i]);

    // Round robin with all three requests held
    pulse_reset();
    for (int i = 0; i < 3; i++) begin c_msg[i] = 2'b01; c_wb[i] = 1'b0; c_endr[i] = 5'(i + 3); end
    pack();
    snoop_shared = '0; snoop_wb = '0; mem_wait = 0;
    ord = '{0, 1, 2, 0};
    k = 0; np = 0; prevg = '0;
    req = 3'b111;
    for (int t = 0; t < 80 && np < 4; t++) begin
      @(posedge clock);
      if (gnt != 0 && prevg == 0) begin
        if (k < 4) chk("rr_gnt", gnt, 32'(1) << ord[k]);
        k++;
      end
      if (pronto != 0) begin
        chk("rr_pronto", pronto, 32'(1) << ord[np]);
        np++;
      end
      prevg = gnt;
    end
    req = '0;
    chk("rr_count", np, 4);
    repeat (3) @(posedge clock);

    // Reset while the victim write-back waits on memory
    c_msg[0] = 2'b11; c_wb[0] = 1'b1; c_vendr[0] = 5'h03; c_vdado[0] = 10'h1A5;
    pack();
    mem_wait = 20;
    req = 3'b001;
    ok = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(posedge clock);
      if (mem_req) begin ok = 1'b1; break; end
    end
    chk("rstwb_reached", {ok, mem_w, mem_endr}, {1'b1, 1'b1, 5'h03});
    #2 reset = 1'b1;
    #1;
    chk("rstwb_mem_req", mem_req, 0);
    chk("rstwb_gnt", gnt, 0);
    req = '0;
    ok = 1'b0;
    repeat (2) begin @(posedge clock); if (pronto != 0) ok = 1'b1; end
    chk("rstwb_no_pronto", ok, 0);
    #2 reset = 1'b0;
    c_msg[0] = 2'b01; c_wb[0] = 1'b0; c_msg[1] = 2'b01; c_wb[1] = 1'b0;
    pack();
    mem_wait = 0;
    @(posedge clock);
    req = 3'b011;
    ok = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(posedge clock);
      if (gnt != 0) begin ok = 1'b1; break; end
    end
    chk("rstwb_first_gnt", gnt, 3'b001);
    req = 3'b000;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clock);
      if (pronto != 0) begin ok = 1'b1; break; end
    end
    chk("drop_req_pronto", {ok, pronto}, {1'b1, 3'b001});
    repeat (3) @(posedge clock);

    // Randomized traffic against the transaction model
    pulse_reset();
    ult_m = 2; busy = 1'b0; to = 1'b0; ntx = 0; w = 0; t0 = 0; e_lat = 0;
    e_sh = 1'b0; e_dado = '0; rq_prev = '0; req = '0;
    for (int cyc = 0; cyc < 15000 && ntx < 250 && !to; cyc++) begin
      @(posedge clock);
      dropped = -1;
      if (!busy) begin
        if (gnt != 0) begin
          w = rr_pick(rq_prev, ult_m);
          chk("rnd_gnt", gnt, (w < 0) ? 32'h0 : (32'(1) << w));
          if (w < 0) w = 0;
          busy = 1'b1; t0 = cyc;
          mem_log.delete();
          snoop_shared = 3'($urandom);
          snoop_wb = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
          snoop_dado = 30'($urandom);
          mem_dado_in = 10'($urandom);
          mem_wait = $urandom_range(0, 2);
          m = (c_msg[w] == 2'b00) ? 2'b01 : c_msg[w];
          e_sh = |(snoop_shared & ~(3'b001 << w));
          wbm = snoop_wb & ~(3'b001 << w);
          own = -1;
          for (int i = 2; i >= 0; i--) if (wbm[i]) own = i;
          exp_q.delete();
          if (m != 2'b10) begin
            if (c_wb[w]) exp_q.push_back(mk(1'b1, c_vendr[w], c_vdado[w]));
            if (own >= 0) exp_q.push_back(mk(1'b1, c_endr[w], snoop_dado[10*own +: 10]));
            else          exp_q.push_back(mk(1'b0, c_endr[w], 10'h0));
          end
          e_dado = (own >= 0) ? snoop_dado[10*own +: 10] : mem_dado_in;
          e_lat = 2 + exp_q.size() * (1 + mem_wait);
        end
      end else if (pronto != 0) begin
        chk("rnd_pronto", pronto, 32'(1) << w);
        chk("rnd_latency", cyc - t0, e_lat);
        chk("rnd_shared", shared_out, e_sh);
        if (exp_q.size() > 0) chk("rnd_dado", dado_out, e_dado);
        ok = (mem_log.size() == exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mem_log.size(); i++)
          if (mem_log[i] != exp_q[i]) ok = 1'b0;
        chk("rnd_mem_seq", ok, 1);
        busy = 1'b0; ult_m = w; req[w] = 1'b0; dropped = w; ntx++;
      end else begin
        chk("rnd_gnt_hold", gnt, 32'(1) << w);
        if (cyc - t0 > 80) begin
          to = 1'b1;
          chk("rnd_timeout", 1, 0);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (!req[i] && i != dropped && $urandom_range(0, 2) == 0) begin
          c_msg[i] = 2'($urandom); c_endr[i] = 5'($urandom); c_wb[i] = 1'($urandom);
          c_vendr[i] = 5'($urandom); c_vdado[i] = 10'($urandom);
          req[i] = 1'b1;
        end
      end
      pack();
      rq_prev = req;
    end
    chk("rnd_tx_count", ntx >= 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/arbitro_barramento.md
# arbitro_barramento

Round-robin arbiter and sequencer for the shared snooping bus between N L1 caches and main memory. It grants one cache at a time, broadcasts the MESI bus message for snooping, and collects the shared and write-back responses. It then orders the memory traffic: victim write-back, snooper write-back or memory read. Finally it returns the line data and a one-cycle completion pulse to the winning cache.

## Interface
Parameters:
- N, 3, number of L1 caches on the bus
- ENDR_W, 5, address width ({tag, index})
- DADO_W, 10, data word width

Ports:
- clock  in  1  system clock; all registers update on the falling edge, the same edge the L1 caches use
- reset  in  1  asynchronous, active-high
- req  in  N  per-cache bus request; held until that cache's pronto
- msg_req  in  2N  per-cache message: 01 read miss, 10 write hit (invalidate), 11 write miss; 00 is never sent to the bus
- endr_req  in  ENDR_W·N  per-cache miss/hit address
- wb_req  in  N  requester has a dirty victim
- endr_wb_req  in  ENDR_W·N  victim address
- dado_wb_req  in  DADO_W·N  victim data
- gnt  out  N  one-hot grant
- pronto  out  N  one-cycle completion pulse to the granted cache
- dado_out  out  DADO_W  line data for the requester; valid while pronto is high
- shared_out  out  1  another cache holds the line; valid while pronto is high
- bus_valido  out  1  snoop cycle strobe
- msg_bus  out  2  broadcast message
- endr_bus  out  ENDR_W  broadcast address
- snoop_shared  in  N  per-cache "line present" response
- snoop_wb  in  N  per-cache "I hold it Modified, abort memory access" response
- snoop_dado  in  DADO_W·N  per-cache Modified data
- mem_req  out  1  memory access request
- mem_w  out  1  1 = write, 0 = read
- mem_endr  out  ENDR_W  memory address
- mem_dado_out  out  DADO_W  memory write data
- mem_dado_in  in  DADO_W  memory read data
- mem_pronto  in  1  memory completes the current access in a cycle where mem_req is high

## Operation
States: OCIOSO, SNOOP, WB_VITIMA, WB_SNOOP, LEITURA, FIM.

**OCIOSO**
- If any req bit is set, select the first set bit searching from ultimo+1 upward, wrapping modulo N.
- Latch the selected index sel, its msg_req, endr_req, wb_req and the victim address/data.
- Set gnt[sel]; go to SNOOP.

**SNOOP (exactly 1 cycle)**
- Drive bus_valido=1, msg_bus and endr_bus from the latched request.
- Mask bit sel out of snoop_shared and snoop_wb.
- Latch shared = OR of the masked snoop_shared.
- Latch owner = lowest set index in the masked snoop_wb, together with its snoop_dado.
- Next state:
  - msg 10 → FIM (invalidate only, no memory access).
  - else wb_req → WB_VITIMA.
  - else an owner exists → WB_SNOOP.
  - else → LEITURA.

**WB_VITIMA**
- mem_req=1, mem_w=1, mem_endr = victim address, mem_dado_out = victim data.
- On mem_pronto: go to WB_SNOOP if an owner exists, else LEITURA.

**WB_SNOOP**
- mem_req=1, mem_w=1, mem_endr = request address, mem_dado_out = owner data.
- On mem_pronto: dado_out ← owner data; go to FIM. No memory read follows.

**LEITURA**
- mem_req=1, mem_w=0, mem_endr = request address.
- On mem_pronto: dado_out ← mem_dado_in; go to FIM.

**FIM**
- pronto[sel]=1 and shared_out = latched shared.
- ultimo ← sel; gnt cleared; go to OCIOSO.

Boundary rules:
- Requests arriving outside OCIOSO wait; no preemption.
- req dropped after grant: the transaction still completes.
- Several snoop_wb bits set (protocol error): the lowest index wins.
- msg_req 00 latched: treat it as 01.

## Timing
- Reset (asynchronous): state OCIOSO, ultimo=N-1 so cache 0 has first priority. Every output is 0: gnt, pronto, dado_out, shared_out, bus_valido, msg_bus, endr_bus, mem_req, mem_w, mem_endr, mem_dado_out. Reset in any state aborts the transaction with no pronto and drops mem_req immediately.
- The grant is registered on the edge that samples req. SNOOP follows on the next edge.
- Invalidate (10): pronto is high in the 3rd cycle after the sampling edge.
- Read with mem_pronto already high: pronto in the 4th cycle. Each memory wait cycle adds 1 cycle per access.
- mem_req stays high, with address and data stable, until the edge that samples mem_pronto. A back-to-back second access may start in the next cycle.
- gnt stays high from grant through FIM inclusive. The next grant is at the earliest the cycle after FIM, so OCIOSO lasts at least 1 cycle.

## Test plan
- **Reset then single read miss.** Stimulus: req[1]=1, msg 01, endr 5'h0A, memory returns 10'h155 with zero wait. Required: gnt=3'b010, one bus_valido cycle with msg_bus=01 and endr_bus=0A, mem read at 0A, pronto[1] with dado_out=155 and shared_out=0.
- **Round robin.** Stimulus: req=3'b111 held continuously. Required: grants in order 0, 1, 2, 0, each exactly one-hot, each followed by its pronto.
- **Dirty victim plus snooper owner.** Stimulus: req0 wm at 0x13, wb_req=1 with victim 0x0B/0x2AA; snoop_wb[2]=1 with data 0x0F0. Required: mem write 0B←2AA, then mem write 13←0F0, no read, dado_out=0F0.
- **Write-hit invalidate.** Stimulus: msg 10, snoop_shared=3'b110. Required: pronto in cycle 3, shared_out=1, mem_req never asserted.
- **Memory wait states.** Stimulus: mem_pronto held low for 4 cycles. Required: mem_req and mem_endr stable for all 5 cycles; pronto 4 cycles later than the zero-wait case.
- **Reset asserted during WB_VITIMA.** Required: mem_req and gnt drop asynchronously; after release, a new request from cache 0 is served first.
